param_fifo_sram: RTL and testbench

Parametrised synchronous FIFO built on a simple dual-port RAM array, next generation of the team's 8-bit FIFO/SRAM buffer. Adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow error flags with explicit clear. It sits between a producer and a consumer running on the same clock, e.g. sample buffering ahead of the FFT datapath.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/param_fifo_sram_sdp_ram.sv | 27 ++
 rtl/param_fifo_sram.sv | 97 +++++++++
 tb/tb_param_fifo_sram.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the parametrised FIFO family.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_AE_LEVEL  = 2;
    localparam int unsigned DEF_AF_MARGIN = 2;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Count needs DEPTH+1 distinct values, hence one bit more than a pointer.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int unsigned data_w, input int unsigned depth,
                                     input int unsigned ae, input int unsigned af);
        return (data_w >= 1) && (data_w <= 64) &&
               (depth >= 4) && (depth <= 1024) && ((depth & (depth - 1)) == 0) &&
               (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/param_fifo_sram_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port, no reset.
module sdp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write on a shared address returns the old word, which the
    // full FIFO relies on when reading and writing the same slot.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_fifo_sram.sv
// Synchronous FIFO over an SDP RAM with occupancy count, thresholds,
// read-valid strobe and sticky overflow/underflow flags.
module param_fifo_sram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      write,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      read,
    output logic [DATA_W-1:0]         data_out,
    output logic                      rd_valid,
    output logic                      ready,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    input  logic                      err_clr,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    if (!params_ok(DATA_W, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_param_check
        $error("param_fifo_sram: illegal DATA_W/DEPTH/AE_LEVEL/AF_LEVEL combination");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] ram_rdata;
    logic              out_zero;
    logic              do_wr;
    logic              do_rd;

    always_comb begin
        ready        = (count != '0);
        full         = (count == CW'(DEPTH));
        almost_full  = (count >= CW'(AF_LEVEL));
        almost_empty = (count <= CW'(AE_LEVEL));
        do_wr        = write & (~full | read);
        do_rd        = read & ready;
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (do_rd),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; out_zero masks it to zero from reset
    // until the first accepted read so data_out still resets without extra latency.
    assign data_out = out_zero ? '0 : ram_rdata;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            out_zero  <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd)
                out_zero <= 1'b0;
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error in the clearing cycle keeps the flag set.
            overflow  <= (write & ~do_wr) | (overflow & ~err_clr);
            underflow <= (read & ~ready) | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_param_fifo_sram.sv
// Directed self-checking bench for param_fifo_sram (DATA_W=8, DEPTH=8).
module tb_param_fifo_sram;

    logic       clk = 1'b0;
    logic       clr;
    logic       write;
    logic [7:0] data_in;
    logic       read;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       ready;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       err_clr;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q [$];
    logic [7:0] exp_word;

    param_fifo_sram #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .write        (write),
        .data_in      (data_in),
        .read         (read),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .ready        (ready),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; write = 1'b0; read = 1'b0; data_in = '0; err_clr = 1'b0;
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_rdv", 32'(rd_valid), 0);
        check("rst_dout", 32'(data_out), 0);
        @(negedge clk);
        clr = 1'b0;
        tick();

        // Fill with E0..E7
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; data_in = 8'hE0 + 8'(i);
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
            check("fill_ae", 32'(almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        write = 1'b0;
        check("fill_full", 32'(full), 1);
        check("fill_ready", 32'(ready), 1);

        // Overflow on write while full
        write = 1'b1; data_in = 8'hF0;
        tick();
        write = 1'b0;
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        // Simultaneous read+write while full
        write = 1'b1; read = 1'b1; data_in = 8'hF1;
        tick();
        write = 1'b0;
        check("fullrw_dout", 32'(data_out), 32'h E0);
        check("fullrw_rdv", 32'(rd_valid), 1);
        check("fullrw_count", 32'(count), 8);
        check("fullrw_ovf", 32'(overflow), 0);

        // Drain: E1..E7 then F1; F0 must never appear
        for (int i = 0; i < 8; i++) begin
            read = 1'b1;
            tick();
            check("drain_dout", 32'(data_out), (i < 7) ? 32'(8'hE1 + 8'(i)) : 32'h F1);
            check("drain_rdv", 32'(rd_valid), 1);
            check("drain_count", 32'(count), 32'(7 - i));
        end
        read = 1'b0;
        check("drain_ready", 32'(ready), 0);
        check("drain_ae", 32'(almost_empty), 1);
        tick();
        check("idle_rdv", 32'(rd_valid), 0);
        check("idle_hold", 32'(data_out), 32'h F1);

        // Empty read+write: write taken, read ignored
        write = 1'b1; read = 1'b1; data_in = 8'hA5;
        tick();
        write = 1'b0;
        check("emprw_udf", 32'(underflow), 1);
        check("emprw_rdv", 32'(rd_valid), 0);
        check("emprw_count", 32'(count), 1);
        check("emprw_hold", 32'(data_out), 32'h F1);
        tick();
        read = 1'b0;
        check("emprw_dout", 32'(data_out), 32'h A5);
        check("emprw_rdv2", 32'(rd_valid), 1);
        check("emprw_cnt2", 32'(count), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("udf_clr", 32'(underflow), 0);

        // Mixed traffic against a queue model; pointers wrap twice
        for (int unsigned c = 0; c < 20; c++) begin
            logic wr_b, rd_b, acc_w, acc_r;
            wr_b = (c % 7) != 6;
            rd_b = (c >= 5) && ((c % 4) != 3);
            acc_r = rd_b && (q.size() > 0);
            acc_w = wr_b && ((q.size() < 8) || rd_b);
            write = wr_b; read = rd_b; data_in = 8'h30 + 8'(c);
            tick();
            if (acc_r) begin
                exp_word = q.pop_front();
                check("mix_dout", 32'(data_out), 32'(exp_word));
            end
            if (acc_w)
                q.push_back(8'h30 + 8'(c));
            check("mix_rdv", 32'(rd_valid), 32'(acc_r));
            check("mix_count", 32'(count), 32'(q.size()));
        end
        write = 1'b0; read = 1'b0;

        for (int i = 0; i < 16 && q.size() > 0; i++) begin
            read = 1'b1;
            tick();
            exp_word = q.pop_front();
            check("mixdrain_dout", 32'(data_out), 32'(exp_word));
        end
        read = 1'b0;
        check("mixdrain_cnt", 32'(count), 0);

        // Fill to 5 then reset asynchronously mid-cycle
        for (int i = 0; i < 5; i++) begin
            write = 1'b1; data_in = 8'h50 + 8'(i);
            tick();
        end
        write = 1'b0;
        check("pre_clr_cnt", 32'(count), 5);
        #2 clr = 1'b1;
        #1;
        check("aclr_count", 32'(count), 0);
        check("aclr_ready", 32'(ready), 0);
        check("aclr_dout", 32'(data_out), 0);
        check("aclr_rdv", 32'(rd_valid), 0);
        check("aclr_ae", 32'(almost_empty), 1);
        @(negedge clk);
        clr = 1'b0;
        read = 1'b1;
        tick();
        read = 1'b0;
        check("post_udf", 32'(underflow), 1);
        check("post_rdv", 32'(rd_valid), 0);
        check("post_dout", 32'(data_out), 0);
        check("post_count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
